// File: rtl/seq_restoring_divider.sv
// Sequential unsigned restoring divider: 2W-bit dividend / W-bit divisor, one quotient bit per clock.
// Optional DIV_EARLY_OUT_EN: finish immediately when the dividend is smaller than the divisor.
module seq_restoring_divider #(
    parameter int W = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [2*W-1:0] dividend,
    input  logic [W-1:0]   divisor,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*W-1:0] quotient,
    output logic [W-1:0]   remainder,
    output logic           div_by_zero
);

    localparam int CW = $clog2(2*W);
    localparam logic [CW-1:0] LAST_BIT = CW'(2*W-1);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t         state_reg, state_next;
    logic [CW-1:0]  count_reg, count_next;
    logic [W:0]     prem_reg, prem_next;
    logic [2*W-1:0] shift_reg, shift_next;
    logic [W-1:0]   dsor_reg, dsor_next;
    logic [2*W-1:0] quot_reg, quot_next;
    logic [W-1:0]   rem_reg, rem_next;
    logic           dbz_reg, dbz_next;

    // One extra bit of headroom so the trial compare never overflows.
    logic [W+1:0]   trial;
    logic           trial_ge;

    assign trial    = {prem_reg, shift_reg[2*W-1]};
    assign trial_ge = (trial >= (W+2)'(dsor_reg));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_reg <= '0;
            prem_reg  <= '0;
            shift_reg <= '0;
            dsor_reg  <= '0;
            quot_reg  <= '0;
            rem_reg   <= '0;
            dbz_reg   <= 1'b0;
        end else begin
            count_reg <= count_next;
            prem_reg  <= prem_next;
            shift_reg <= shift_next;
            dsor_reg  <= dsor_next;
            quot_reg  <= quot_next;
            rem_reg   <= rem_next;
            dbz_reg   <= dbz_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        count_next = count_reg;
        prem_next  = prem_reg;
        shift_next = shift_reg;
        dsor_next  = dsor_reg;
        quot_next  = quot_reg;
        rem_next   = rem_reg;
        dbz_next   = dbz_reg;

        case (state_reg)
            IDLE: begin
                if (in_valid) begin
                    if (divisor == '0) begin
                        quot_next  = '1;
                        rem_next   = dividend[W-1:0];
                        dbz_next   = 1'b1;
                        state_next = DONE;
                    end
`ifdef DIV_EARLY_OUT_EN
                    else if (dividend < {{W{1'b0}}, divisor}) begin
                        quot_next  = '0;
                        rem_next   = dividend[W-1:0];
                        dbz_next   = 1'b0;
                        state_next = DONE;
                    end
`endif
                    else begin
                        dsor_next  = divisor;
                        prem_next  = '0;
                        shift_next = dividend;
                        count_next = '0;
                        state_next = CALC;
                    end
                end
            end

            CALC: begin
                // Dividend bits leave at the top while quotient bits enter at the bottom.
                if (trial_ge) begin
                    prem_next  = (W+1)'(trial - (W+2)'(dsor_reg));
                    shift_next = {shift_reg[2*W-2:0], 1'b1};
                end else begin
                    prem_next  = (W+1)'(trial);
                    shift_next = {shift_reg[2*W-2:0], 1'b0};
                end
                count_next = count_reg + CW'(1);
                if (count_reg == LAST_BIT) begin
                    quot_next  = shift_next;
                    rem_next   = prem_next[W-1:0];
                    dbz_next   = 1'b0;
                    count_next = '0;
                    state_next = DONE;
                end
            end

            DONE: begin
                if (out_ready) begin
                    state_next = IDLE;
                end
            end

            default: state_next = IDLE;
        endcase
    end

    assign in_ready    = (state_reg == IDLE);
    assign out_valid   = (state_reg == DONE);
    assign quotient    = quot_reg;
    assign remainder   = rem_reg;
    assign div_by_zero = dbz_reg;

endmodule

// File: tb/tb_seq_restoring_divider.sv
// Self-checking bench for seq_restoring_divider (W=8): directed products, extremes, backpressure,
// reset mid-calculation and randomized operands against an arithmetic reference.
module tb_seq_restoring_divider;

`ifdef DIV_EARLY_OUT_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] dividend;
    logic [7:0]  divisor;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] quotient;
    logic [7:0]  remainder;
    logic        div_by_zero;

    int total = 0;
    int bad   = 0;

    seq_restoring_divider #(.W(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .dividend   (dividend),
        .divisor    (divisor),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .quotient   (quotient),
        .remainder  (remainder),
        .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: plain integer division with the divide-by-zero convention.
    task automatic reference(input logic [15:0] dvd, input logic [7:0] dsr,
                             output logic [15:0] q, output logic [7:0] r,
                             output logic z, output int lat);
        if (dsr == 8'd0) begin
            q = 16'hFFFF; r = dvd[7:0]; z = 1'b1; lat = 1;
        end else begin
            q = dvd / {8'd0, dsr};
            r = 8'(dvd % {8'd0, dsr});
            z = 1'b0;
            lat = (EARLY && dvd < {8'd0, dsr}) ? 1 : 17;
        end
    endtask

    task automatic do_div(input string tag, input logic [15:0] dvd, input logic [7:0] dsr,
                          input int hold, input bit scramble);
        logic [15:0] eq;
        logic [7:0]  er;
        logic        ez;
        int          elat;
        int          edges;
        int          waits;
        reference(dvd, dsr, eq, er, ez, elat);
        waits = 0;
        while (!in_ready && waits < 50) begin
            tick();
            waits++;
        end
        check({tag, ":ready_wait"}, 32'(in_ready), 32'd1);
        out_ready = (hold == 0);
        in_valid  = 1'b1;
        dividend  = dvd;
        divisor   = dsr;
        tick();
        edges = 1;
        in_valid = 1'b0;
        while (!out_valid && edges < 40) begin
            if (scramble) begin
                dividend = 16'($urandom);
                divisor  = 8'($urandom);
                in_valid = 1'($urandom);
            end
            tick();
            edges++;
        end
        in_valid = 1'b0;
        check({tag, ":latency"}, 32'(edges), 32'(elat));
        check({tag, ":quotient"}, 32'(quotient), 32'(eq));
        check({tag, ":remainder"}, 32'(remainder), 32'(er));
        check({tag, ":dbz"}, 32'(div_by_zero), 32'(ez));
        $display("div %s: %0d/%0d -> q=%0d r=%0d dbz=%0d latency=%0d", tag, dvd, dsr,
                 quotient, remainder, div_by_zero, edges);
        for (int i = 0; i < hold; i++) begin
            check({tag, ":bp_in_ready"}, 32'(in_ready), 32'd0);
            in_valid = 1'b1;
            dividend = 16'($urandom);
            divisor  = 8'($urandom_range(1, 255));
            tick();
            check({tag, ":bp_valid"}, 32'(out_valid), 32'd1);
            check({tag, ":bp_quotient"}, 32'(quotient), 32'(eq));
            check({tag, ":bp_remainder"}, 32'(remainder), 32'(er));
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        check({tag, ":release_valid"}, 32'(out_valid), 32'd0);
        check({tag, ":release_ready"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        dividend = '0; divisor = '0;
        tick();
        tick();
        check("reset:in_ready", 32'(in_ready), 32'd1);
        check("reset:out_valid", 32'(out_valid), 32'd0);
        check("reset:quotient", 32'(quotient), 32'd0);
        check("reset:remainder", 32'(remainder), 32'd0);
        check("reset:dbz", 32'(div_by_zero), 32'd0);
        rst = 1'b0;
        tick();

        do_div("p30_6", 16'd30, 8'd6, 0, 1'b0);
        do_div("p65025_255", 16'd65025, 8'd255, 0, 1'b0);
        do_div("p16256_127", 16'd16256, 8'd127, 0, 1'b0);
        do_div("p14450_170", 16'd14450, 8'd170, 0, 1'b0);
        do_div("r1000_7", 16'd1000, 8'd7, 0, 1'b0);
        do_div("max_1", 16'd65535, 8'd1, 0, 1'b0);
        do_div("small_5_6", 16'd5, 8'd6, 0, 1'b0);
        do_div("zero_div", 16'd1234, 8'd0, 0, 1'b0);
        do_div("backpressure", 16'd1000, 8'd7, 5, 1'b0);
        do_div("scramble", 16'd54321, 8'd99, 0, 1'b1);

        // Reset during CALC: accept edge is edge 1, reset applied on edge 8.
        out_ready = 1'b1;
        in_valid = 1'b1; dividend = 16'd30; divisor = 8'd6;
        tick();
        in_valid = 1'b0;
        for (int i = 2; i < 8; i++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst:out_valid", 32'(out_valid), 32'd0);
        check("midrst:in_ready", 32'(in_ready), 32'd1);
        check("midrst:quotient", 32'(quotient), 32'd0);
        check("midrst:remainder", 32'(remainder), 32'd0);
        $display("reset mid-calc: out_valid=%0d in_ready=%0d q=%0d r=%0d",
                 out_valid, in_ready, quotient, remainder);
        do_div("after_rst", 16'd1000, 8'd7, 0, 1'b0);

        for (int n = 0; n < 24; n++) begin
            logic [15:0] rd;
            logic [7:0]  rs;
            rd = 16'($urandom);
            case (n % 4)
                0: rs = 8'd0;
                1: begin rs = 8'($urandom_range(1, 255)); rd = 16'($urandom_range(0, 300)); end
                default: rs = 8'($urandom_range(1, 255));
            endcase
            do_div($sformatf("rand%0d", n), rd, rs, n % 3, n[0]);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
